uart_tx_cfg: RTL and testbench



---
 rtl/uart_tx_cfg_pkg.sv | 22 ++
 rtl/uart_tx_cfg_if.sv | 29 ++
 rtl/uart_fifo.sv | 54 +++++
 rtl/uart_tx_cfg.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_cfg_pkg.sv
// Shared definitions for the configurable UART transmitter:
// parity encodings, FSM states and 12 MHz baud divisor helper.
package uart_tx_cfg_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  // Rounded clocks-per-bit at 12 MHz, e.g. 300 -> 40000, 115200 -> 104.
  function automatic int div_12m(int baud);
    return (12_000_000 + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Write-side handshake and serial line of the UART transmitter.
// The master writes words; the slave reports ready/busy and drives tx.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);

  logic                 start;
  logic [DATA_BITS-1:0] data;
  logic                 ready;
  logic                 busy;
  logic                 tx;

  modport master (
    output start,
    output data,
    input  ready,
    input  busy,
    input  tx
  );

  modport slave (
    input  start,
    input  data,
    output ready,
    output busy,
    output tx
  );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with async active-high reset.
// Writes when full and reads when empty are ignored.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign w_wr = wr_en && !full;
  assign w_rd = rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= wr_data;
  end

  assign rd_data = r_mem[r_rp];
  assign full    = (r_cnt == FULL_CNT);
  assign empty   = (r_cnt == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-buffered, back-to-back frames
// with selectable data width, parity and stop bits.
module uart_tx_cfg
  import uart_tx_cfg_pkg::*;
#(
  parameter int CLK_DIV    = div_12m(115200),
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_cfg_if.slave bus
);

  localparam int BCW = $clog2(CLK_DIV);
  localparam int NW  = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] BAUD_TOP = BCW'(CLK_DIV - 1);
  localparam logic [NW-1:0]  DATA_TOP = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0]  STOP_TOP = NW'(STOP_BITS - 1);
  localparam logic           ODD      = (PARITY == PAR_ODD);

  if (CLK_DIV < 2 || CLK_DIV > 65535 ||
      DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_tx_cfg: parameter out of range");
  end

  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_head;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.start),
    .wr_data (bus.data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  state_t               r_state;
  state_t               w_state;
  logic [BCW-1:0]       r_baud;
  logic [NW-1:0]        r_bit;
  logic [NW-1:0]        w_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift;
  logic                 r_par;
  logic                 w_par;
  logic                 r_tx;
  logic                 w_tx;
  logic                 w_tick;

  assign w_tick = (r_baud == BAUD_TOP);

  always_comb begin
    w_state = r_state;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_par   = r_par;
    w_tx    = r_tx;
    w_pop   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_tx = 1'b1;
        if (!w_empty) begin
          w_pop   = 1'b1;
          w_state = S_START;
          w_tx    = 1'b0;
          w_shift = w_head;
          w_par   = (^w_head) ^ ODD;
          w_bit   = '0;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state = S_DATA;
          w_tx    = r_shift[0];
          w_shift = r_shift >> 1;
          w_bit   = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit == DATA_TOP) begin
            w_bit = '0;
            if (PARITY != PAR_NONE) begin
              w_state = S_PAR;
              w_tx    = r_par;
            end else begin
              w_state = S_STOP;
              w_tx    = 1'b1;
            end
          end else begin
            w_bit   = r_bit + 1'b1;
            w_tx    = r_shift[0];
            w_shift = r_shift >> 1;
          end
        end
      end
      S_PAR: begin
        if (w_tick) begin
          w_state = S_STOP;
          w_tx    = 1'b1;
          w_bit   = '0;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_bit != STOP_TOP) begin
            w_bit = r_bit + 1'b1;
          end else if (!w_empty) begin
            // Chain straight into the next start bit: no idle gap.
            w_pop   = 1'b1;
            w_state = S_START;
            w_tx    = 1'b0;
            w_shift = w_head;
            w_par   = (^w_head) ^ ODD;
            w_bit   = '0;
          end else begin
            w_state = S_IDLE;
            w_tx    = 1'b1;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_par   <= w_par;
      r_tx    <= w_tx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud <= '0;
    end else if (w_pop || r_state == S_IDLE) begin
      r_baud <= '0;
    end else if (w_tick) begin
      r_baud <= '0;
    end else begin
      r_baud <= r_baud + 1'b1;
    end
  end

  assign bus.ready = !w_full;
  assign bus.busy  = (r_state != S_IDLE) || !w_empty;
  assign bus.tx    = r_tx;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench: three transmitter configurations (8N1, 8E1, 7O2),
// each with a frame monitor checking against a bit-level frame model.
module tb_uart_tx_cfg;

  localparam int NDUT = 3;
  localparam int CD [NDUT] = '{4, 4, 5};
  localparam int DB [NDUT] = '{8, 8, 7};
  localparam int PA [NDUT] = '{0, 1, 2};
  localparam int SB [NDUT] = '{1, 1, 2};
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst_a   [NDUT];
  logic       start_a [NDUT];
  logic [8:0] data_a  [NDUT];
  logic       ready_a [NDUT];
  logic       busy_a  [NDUT];
  logic       tx_a    [NDUT];

  logic [8:0] exp_q [NDUT][$];
  int         st_q  [NDUT][$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int fb(int g);
    return 1 + DB[g] + (PA[g] != 0 ? 1 : 0) + SB[g];
  endfunction

  function automatic int fl(int g);
    return CD[g] * fb(g);
  endfunction

  // Line levels of one frame, index 0 = start bit; unused bits idle high.
  function automatic logic [15:0] frame(int g, logic [8:0] d);
    logic [15:0] f;
    int ones;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < DB[g]; i++) begin
      f[1+i] = d[i];
      ones += int'(d[i]);
    end
    if (PA[g] == 1) f[1+DB[g]] = (ones % 2 == 1);
    if (PA[g] == 2) f[1+DB[g]] = (ones % 2 == 0);
    return f;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : u
    uart_tx_cfg_if #(.DATA_BITS(DB[g])) bus ();

    assign bus.start  = start_a[g];
    assign bus.data   = data_a[g][DB[g]-1:0];
    assign ready_a[g] = bus.ready;
    assign busy_a[g]  = bus.busy;
    assign tx_a[g]    = bus.tx;

    uart_tx_cfg #(
      .CLK_DIV    (CD[g]),
      .DATA_BITS  (DB[g]),
      .PARITY     (PA[g]),
      .STOP_BITS  (SB[g]),
      .FIFO_DEPTH (FD)
    ) dut (
      .clk (clk),
      .rst (rst_a[g]),
      .bus (bus)
    );

    initial begin : mon
      logic [15:0] got;
      logic [15:0] want;
      logic [8:0]  d;
      logic        stable;
      logic        bz;
      logic        abort;
      forever begin
        @(negedge clk);
        if (rst_a[g] === 1'b0 && tx_a[g] === 1'b0) begin
          st_q[g].push_back(cyc);
          got = '1;
          stable = 1'b1;
          bz = 1'b1;
          abort = 1'b0;
          for (int b = 0; b < fb(g) && !abort; b++) begin
            for (int c = 0; c < CD[g] && !abort; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (rst_a[g] !== 1'b0) abort = 1'b1;
              else if (c == 0) got[b] = tx_a[g];
              else if (tx_a[g] !== got[b]) stable = 1'b0;
              if (!abort && busy_a[g] !== 1'b1) bz = 1'b0;
            end
          end
          if (!abort) begin
            if (exp_q[g].size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL dut%0d_frame: got %0h required none",
                       g, got);
            end else begin
              d = exp_q[g].pop_front();
              want = frame(g, d);
              chk($sformatf("dut%0d_frame", g),
                  32'(got), 32'(want));
              chk($sformatf("dut%0d_bit_hold", g),
                  32'(stable), 32'd1);
              chk($sformatf("dut%0d_busy_in_frame", g),
                  32'(bz), 32'd1);
            end
          end
        end
      end
    end
  end

  task automatic wr(int g, logic [8:0] d, logic exp_rdy);
    chk($sformatf("dut%0d_ready_at_write", g),
        32'(ready_a[g]), 32'(exp_rdy));
    start_a[g] = 1'b1;
    data_a[g] = d;
    if (exp_rdy) exp_q[g].push_back(d & 9'((1 << DB[g]) - 1));
    @(negedge clk);
    start_a[g] = 1'b0;
  endtask

  task automatic wait_idle(int g);
    int i = 0;
    while (busy_a[g] === 1'b1 && i < 4000) begin
      @(negedge clk);
      i++;
    end
    chk($sformatf("dut%0d_idle", g), 32'(busy_a[g]), 32'd0);
    @(negedge clk);
  endtask

  // Single write into an idle DUT with latency and frame-length checks.
  task automatic one_frame(int g, logic [8:0] d);
    wr(g, d, 1'b1);
    chk($sformatf("dut%0d_tx_at_k", g), 32'(tx_a[g]), 32'd1);
    chk($sformatf("dut%0d_busy_at_k", g), 32'(busy_a[g]), 32'd1);
    @(negedge clk);
    chk($sformatf("dut%0d_tx_at_k1", g), 32'(tx_a[g]), 32'd0);
    repeat (fl(g)) @(negedge clk);
    chk($sformatf("dut%0d_busy_end", g), 32'(busy_a[g]), 32'd0);
    chk($sformatf("dut%0d_tx_end", g), 32'(tx_a[g]), 32'd1);
  endtask

  task automatic rand_bursts(int g, int n);
    int len;
    for (int k = 0; k < n; k++) begin
      len = $urandom_range(1, FD + 1);
      for (int j = 0; j < len; j++) begin
        wr(g, 9'($urandom), 1'b1);
        repeat ($urandom_range(0, 2 * CD[g])) @(negedge clk);
      end
      wait_idle(g);
    end
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    for (int g = 0; g < NDUT; g++) begin
      rst_a[g] = 1'b1;
      start_a[g] = 1'b0;
      data_a[g] = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("dut%0d_rst_ready", g), 32'(ready_a[g]), 32'd1);
      chk($sformatf("dut%0d_rst_busy", g), 32'(busy_a[g]), 32'd0);
      chk($sformatf("dut%0d_rst_tx", g), 32'(tx_a[g]), 32'd1);
      rst_a[g] = 1'b0;
    end
    @(negedge clk);

    one_frame(0, 9'h0A5);

    st_q[0].delete();
    for (int i = 1; i <= 6; i++) wr(0, 9'(i), i <= 5);
    wait_idle(0);
    chk("t4_frames", 32'(st_q[0].size()), 32'd5);
    for (int i = 1; i < st_q[0].size(); i++)
      chk($sformatf("t4_gap%0d", i),
          32'(st_q[0][i] - st_q[0][i-1]), 32'(fl(0)));

    st_q[0].delete();
    wr(0, 9'h011, 1'b1);
    wr(0, 9'h022, 1'b1);
    wr(0, 9'h033, 1'b1);
    begin
      int i = 0;
      while (st_q[0].size() < 2 && i < 1000) begin
        @(negedge clk);
        i++;
      end
    end
    chk("t5_second_start", 32'(st_q[0].size()), 32'd2);
    repeat (3 * CD[0]) @(negedge clk);
    #1 rst_a[0] = 1'b1;
    exp_q[0].delete();
    #1;
    chk("t5_rst_tx", 32'(tx_a[0]), 32'd1);
    chk("t5_rst_busy", 32'(busy_a[0]), 32'd0);
    chk("t5_rst_ready", 32'(ready_a[0]), 32'd1);
    repeat (3) @(negedge clk);
    rst_a[0] = 1'b0;
    repeat (200) @(negedge clk);
    chk("t5_no_resume", 32'(st_q[0].size()), 32'd2);
    chk("t5_idle_tx", 32'(tx_a[0]), 32'd1);
    one_frame(0, 9'h05A);

    wr(0, 9'h03C, 1'b1);
    data_a[0] = 9'h0C3;
    wait_idle(0);
    rand_bursts(0, 5);

    st_q[1].delete();
    one_frame(1, 9'h007);
    one_frame(1, 9'h003);
    wr(1, 9'h0E1, 1'b1);
    wr(1, 9'h05B, 1'b1);
    wait_idle(1);
    chk("t2_frame_len", 32'(st_q[1][3] - st_q[1][2]), 32'(fl(1)));
    rand_bursts(1, 5);

    one_frame(2, 9'h000);
    rand_bursts(2, 5);

    repeat (10) @(negedge clk);
    for (int g = 0; g < NDUT; g++)
      chk($sformatf("dut%0d_sb_empty", g),
          32'(exp_q[g].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
